add_accum: RTL and testbench
============================

// Module: add_accum
// PURPOSE
//  Multi-operand accumulator stage placed directly downstream of the 16-bit carry-lookahead adder.
//  Takes a stream of W-bit operands, one per valid/ready beat, and sums each packet (terminated by in_last) through the CLA.
//  Presents the packet sum, an overflow flag and a beat count on a valid/ready output.
//  Registers the adder result every cycle, so the combinational CLA never sits in a multi-cycle path.
// PARAMETERS
//  W      16  operand/sum width; multiple of 4 (4-bit lookahead groups)
//  CNT_W  8   width of beat counter out_count
// PORTS
//  clk        in   1      single clock, rising edge
//  rst_n      in   1      reset, asynchronous assert, active-low
//  in_valid   in   1      operand beat valid
//  in_ready   out  1      stage can accept a beat
//  in_data    in   W      operand, unsigned
//  in_last    in   1      beat is last of packet
//  out_valid  out  1      packet result valid
//  out_ready  in   1      consumer accepts result
//  out_sum    out  W      packet sum (mod 2^W, or saturated, see CONFIGURATION)
//  out_ovf    out  1      sticky: any add in packet produced carry-out
//  out_count  out  CNT_W  beats in packet, saturating at 2^CNT_W-1
// BEHAVIOUR
//  Reset (rst_n=0, async): state=IDLE, acc=0, ovf=0, cnt=0, out_valid=0. in_ready=1 (combinational, state!=HOLD).
//  Beat accepted when in_valid && in_ready. Adder inputs: (state==IDLE ? 0 : acc) + in_data, carry-in 0.
//  States:
//   IDLE   no beats yet. On beat: acc<=sum, ovf<=cout, cnt<=1. Goes to HOLD if in_last, else to ACCUM.
//   ACCUM  on beat: acc<=sum, ovf<=ovf|cout, cnt<=sat_inc(cnt). Goes to HOLD if in_last. No beat: hold everything.
//   HOLD   out_valid=1, in_ready=0; out_sum/out_ovf/out_count stable. On out_ready goes to IDLE next edge.
//  Latency: out_valid rises on the clock edge that captures the last beat's sum, i.e. visible the cycle after the last beat.
//  Throughput: one beat per cycle inside a packet. One bubble per packet: the HOLD->IDLE handshake cycle accepts no beat.
//  Single-beat packet (in_last on first beat): IDLE->HOLD directly, out_sum=in_data, out_ovf=0.
//  out_* driven from registers. out_sum=acc, out_ovf=ovf, out_count=cnt in every state. Only out_valid qualifies them.
//  cnt saturates at all-ones and never wraps. ovf stays set until the packet leaves.
//  in_last with in_valid=0 is ignored. in_data is don't-care when no beat is accepted.
//  Reset mid-packet or in HOLD: partial or pending result discarded, back to IDLE.
// CONFIGURATION
//  Macro ADD_ACCUM_SATURATE_EN:
//   defined: on cout, acc<=all-ones. Once acc is all-ones it stays all-ones for the rest of the packet. ovf is still set.
//   undefined: acc<=sum, wrapping mod 2^W. ovf marks the wrap.
// STRUCTURE
//  Package add_accum_pkg:
//   localparam W_DEF=16
//   typedef logic [W_DEF-1:0] word_t
//   typedef enum logic [1:0] {IDLE, ACCUM, HOLD} acc_state_t
//  Sub-module cla_add (W-bit carry-lookahead adder, 4-bit groups, ports sum, cout, a, b, cin):
//   one instance, purely combinational.
//   all sequencing lives in add_accum.
// TESTING
//  Reset -> out_valid=0, in_ready=1, out_sum=0x0000, out_ovf=0, out_count=0.
//  Beats 0x0001, 0x0002, 0x0003(last), out_ready=1 -> cycle after last: out_sum=0x0006, ovf=0, count=3.
//   Next cycle: IDLE.
//  Beats 0xFFFF, 0x0002(last) -> macro off: sum=0x0001, ovf=1. Macro on: sum=0xFFFF, ovf=1. Count=2 in both.
//  Result pending, out_ready=0 for 5 cycles with in_valid=1 -> in_ready=0, no beat taken, out_* stable.
//   After handshake, next packet 0x0010(last) -> sum=0x0010.
//  Single beat 0x1234(last) -> sum=0x1234, ovf=0, count=1, out_valid one cycle later.
//  Two beats 0x0100, 0x0200, then rst_n pulse low -> all outputs reset.
//   Next packet 0x0005(last) -> sum=0x0005, count=1.

Source files
------------

// File: rtl/add_accum_pkg.sv
// Shared types for the add_accum packet accumulator.
// The default operand width lives here so the top and the bench agree on it.
package add_accum_pkg;

    localparam int unsigned W_DEF = 16;

    typedef logic [W_DEF-1:0] word_t;

    typedef enum logic [1:0] {
        IDLE,
        ACCUM,
        HOLD
    } acc_state_t;

endpackage

// File: rtl/cla_add.sv
// Combinational W-bit carry-lookahead adder built from 4-bit lookahead groups.
// Group carries ripple group-to-group; each group resolves its internal carries in parallel.
module cla_add #(
    parameter int unsigned W = 16
) (
    output logic [W-1:0] sum,
    output logic         cout,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         cin
);

    localparam int unsigned NG = W / 4;

    always_comb begin
        logic [W-1:0] g;
        logic [W-1:0] p;
        logic [W:0]   c;
        logic         grp_g;
        logic         grp_p;
        g    = a & b;
        p    = a ^ b;
        c    = '0;
        c[0] = cin;
        for (int grp = 0; grp < NG; grp++) begin
            c[4*grp+1] = g[4*grp] | (p[4*grp] & c[4*grp]);
            c[4*grp+2] = g[4*grp+1] | (p[4*grp+1] & g[4*grp])
                       | (p[4*grp+1] & p[4*grp] & c[4*grp]);
            c[4*grp+3] = g[4*grp+2] | (p[4*grp+2] & g[4*grp+1])
                       | (p[4*grp+2] & p[4*grp+1] & g[4*grp])
                       | (p[4*grp+2] & p[4*grp+1] & p[4*grp] & c[4*grp]);
            grp_g = g[4*grp+3] | (p[4*grp+3] & g[4*grp+2])
                  | (p[4*grp+3] & p[4*grp+2] & g[4*grp+1])
                  | (p[4*grp+3] & p[4*grp+2] & p[4*grp+1] & g[4*grp]);
            grp_p = p[4*grp+3] & p[4*grp+2] & p[4*grp+1] & p[4*grp];
            c[4*grp+4] = grp_g | (grp_p & c[4*grp]);
        end
        sum  = p ^ c[W-1:0];
        cout = c[W];
    end

endmodule

// File: rtl/add_accum.sv
// Packet accumulator: sums W-bit operand beats through cla_add until in_last, then holds the result.
// Define ADD_ACCUM_SATURATE_EN to clamp the sum at all-ones instead of wrapping.
module add_accum
    import add_accum_pkg::*;
#(
    parameter int unsigned W     = W_DEF,
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W-1:0]     in_data,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [W-1:0]     out_sum,
    output logic             out_ovf,
    output logic [CNT_W-1:0] out_count
);

    acc_state_t       state_q, state_d;
    logic [W-1:0]     acc_q, acc_d;
    logic             ovf_q, ovf_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic             beat;
    logic [W-1:0]     add_a;
    logic [W-1:0]     add_sum;
    logic             add_cout;
    logic [W-1:0]     acc_new;

    assign in_ready = (state_q != HOLD);
    assign beat     = in_valid && in_ready;
    // First beat of a packet starts from zero rather than the stale accumulator.
    assign add_a    = (state_q == IDLE) ? '0 : acc_q;

    cla_add #(
        .W(W)
    ) u_cla_add (
        .sum  (add_sum),
        .cout (add_cout),
        .a    (add_a),
        .b    (in_data),
        .cin  (1'b0)
    );

`ifdef ADD_ACCUM_SATURATE_EN
    assign acc_new = add_cout ? '1 : add_sum;
`else
    assign acc_new = add_sum;
`endif

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        ovf_d   = ovf_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (beat) begin
                    acc_d   = acc_new;
                    ovf_d   = add_cout;
                    cnt_d   = CNT_W'(1);
                    state_d = in_last ? HOLD : ACCUM;
                end
            end
            ACCUM: begin
                if (beat) begin
                    acc_d = acc_new;
                    ovf_d = ovf_q | add_cout;
                    cnt_d = (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1);
                    if (in_last) begin
                        state_d = HOLD;
                    end
                end
            end
            HOLD: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            acc_q   <= '0;
            ovf_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            ovf_q   <= ovf_d;
            cnt_q   <= cnt_d;
        end
    end

    assign out_valid = (state_q == HOLD);
    assign out_sum   = acc_q;
    assign out_ovf   = ovf_q;
    assign out_count = cnt_q;

endmodule

// File: tb/tb_add_accum.sv
// Self-checking bench for add_accum: vector table, hand-written corner sequences, random packets.
// Expected results come from whole-packet arithmetic on the beat values.
module tb_add_accum;

    localparam int unsigned W     = 16;
    localparam int unsigned CNT_W = 8;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [W-1:0]     in_data;
    logic             in_last;
    logic             out_valid;
    logic             out_ready;
    logic [W-1:0]     out_sum;
    logic             out_ovf;
    logic [CNT_W-1:0] out_count;

    int checks = 0;
    int errors = 0;

    add_accum #(
        .W     (W),
        .CNT_W (CNT_W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_ovf   (out_ovf),
        .out_count (out_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        string        name;
        int           n;
        logic [W-1:0] d [0:7];
        logic [W-1:0] exp_sum;
        logic         exp_ovf;
        logic [7:0]   exp_cnt;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Reference: carry-outs happen iff the true total exceeds the word range, in either mode.
    function automatic logic [W-1:0] model_sum(input longint total);
`ifdef ADD_ACCUM_SATURATE_EN
        return (total > 65535) ? 16'hFFFF : W'(total);
`else
        return W'(total % 65536);
`endif
    endfunction

    task automatic run_packet(input string name, input logic [W-1:0] d [0:7], input int n,
                              input bit gaps, input int hold, input logic [W-1:0] exp_sum,
                              input logic exp_ovf, input logic [7:0] exp_cnt);
        int cyc;
        logic [W-1:0] held;
        for (int i = 0; i < n; i++) begin
            if (gaps && $urandom_range(0, 1) == 1) begin
                @(negedge clk);
                in_valid = 1'b0;
                in_last  = 1'b1;
                in_data  = W'($urandom);
                @(posedge clk);
            end
            @(negedge clk);
            cyc = 0;
            while (!in_ready && cyc < 20) begin
                @(negedge clk);
                cyc++;
            end
            if (!in_ready) check({name, "_ready_timeout"}, 32'(in_ready), 32'd1);
            if (i > 0) check({name, "_busy_valid"}, 32'(out_valid), 32'd0);
            in_valid = 1'b1;
            in_data  = d[i];
            in_last  = (i == n - 1);
            @(posedge clk);
        end
        @(negedge clk);
        in_valid  = 1'b0;
        in_last   = 1'b0;
        out_ready = (hold == 0);
        check({name, "_valid"}, 32'(out_valid), 32'd1);
        check({name, "_sum"}, 32'(out_sum), 32'(exp_sum));
        check({name, "_ovf"}, 32'(out_ovf), 32'(exp_ovf));
        check({name, "_count"}, 32'(out_count), 32'(exp_cnt));
        held = out_sum;
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            check({name, "_hold_valid"}, 32'(out_valid), 32'd1);
            check({name, "_hold_sum"}, 32'(out_sum), 32'(held));
        end
        out_ready = 1'b1;
        @(negedge clk);
        check({name, "_idle_valid"}, 32'(out_valid), 32'd0);
        check({name, "_idle_ready"}, 32'(in_ready), 32'd1);
    endtask

    vec_t vecs [0:4];
    logic [W-1:0] buf_d [0:7];

    initial begin
        vecs[0] = '{"abc", 3, '{16'h0001, 16'h0002, 16'h0003, 0, 0, 0, 0, 0},
                    16'h0006, 1'b0, 8'd3};
`ifdef ADD_ACCUM_SATURATE_EN
        vecs[1] = '{"wrap", 2, '{16'hFFFF, 16'h0002, 0, 0, 0, 0, 0, 0}, 16'hFFFF, 1'b1, 8'd2};
        vecs[3] = '{"twice", 3, '{16'h8000, 16'h8000, 16'h0001, 0, 0, 0, 0, 0},
                    16'hFFFF, 1'b1, 8'd3};
`else
        vecs[1] = '{"wrap", 2, '{16'hFFFF, 16'h0002, 0, 0, 0, 0, 0, 0}, 16'h0001, 1'b1, 8'd2};
        vecs[3] = '{"twice", 3, '{16'h8000, 16'h8000, 16'h0001, 0, 0, 0, 0, 0},
                    16'h0001, 1'b1, 8'd3};
`endif
        vecs[2] = '{"single", 1, '{16'h1234, 0, 0, 0, 0, 0, 0, 0}, 16'h1234, 1'b0, 8'd1};
        vecs[4] = '{"zeros", 2, '{16'h0000, 16'h0000, 0, 0, 0, 0, 0, 0}, 16'h0000, 1'b0, 8'd2};

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        in_last   = 1'b0;
        out_ready = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_ready", 32'(in_ready), 32'd1);
        check("rst_sum", 32'(out_sum), 32'd0);
        check("rst_ovf", 32'(out_ovf), 32'd0);
        check("rst_count", 32'(out_count), 32'd0);
        rst_n = 1'b1;

        for (int v = 0; v < 5; v++) begin
            run_packet(vecs[v].name, vecs[v].d, vecs[v].n, 1'b0, 0,
                       vecs[v].exp_sum, vecs[v].exp_ovf, vecs[v].exp_cnt);
        end

        // Result held against back-pressure while the source keeps offering beats.
        @(negedge clk);
        in_valid = 1'b1; in_data = 16'hABCD; in_last = 1'b1; out_ready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        in_data = 16'h1111;
        for (int k = 0; k < 5; k++) begin
            check("stall_ready", 32'(in_ready), 32'd0);
            check("stall_valid", 32'(out_valid), 32'd1);
            check("stall_sum", 32'(out_sum), 32'hABCD);
            check("stall_count", 32'(out_count), 32'd1);
            @(negedge clk);
        end
        in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b1;
        @(negedge clk);
        check("stall_release", 32'(out_valid), 32'd0);
        buf_d = '{16'h0010, 0, 0, 0, 0, 0, 0, 0};
        run_packet("after_stall", buf_d, 1, 1'b0, 0, 16'h0010, 1'b0, 8'd1);

        // Beat counter saturation over a long zero packet.
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            in_valid = 1'b1; in_data = '0; in_last = (i == 299);
            @(posedge clk);
        end
        @(negedge clk);
        in_valid = 1'b0; in_last = 1'b0;
        check("sat_valid", 32'(out_valid), 32'd1);
        check("sat_count", 32'(out_count), 32'd255);
        check("sat_sum", 32'(out_sum), 32'd0);
        @(negedge clk);

        // Reset in the middle of a packet drops the partial sum.
        @(negedge clk);
        in_valid = 1'b1; in_data = 16'h0100; in_last = 1'b0;
        @(posedge clk);
        @(negedge clk);
        in_data = 16'h0200;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check("midrst_valid", 32'(out_valid), 32'd0);
        check("midrst_ready", 32'(in_ready), 32'd1);
        check("midrst_sum", 32'(out_sum), 32'd0);
        check("midrst_ovf", 32'(out_ovf), 32'd0);
        check("midrst_count", 32'(out_count), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        buf_d = '{16'h0005, 0, 0, 0, 0, 0, 0, 0};
        run_packet("post_rst", buf_d, 1, 1'b0, 0, 16'h0005, 1'b0, 8'd1);

        // Random packets with idle gaps and variable back-pressure.
        for (int r = 0; r < 40; r++) begin
            int     n;
            longint total;
            n     = $urandom_range(1, 8);
            total = 0;
            for (int i = 0; i < 8; i++) begin
                buf_d[i] = ($urandom_range(0, 3) == 0) ? W'($urandom_range(16'hF000, 16'hFFFF))
                                                       : W'($urandom_range(0, 16'h3FFF));
                if (i < n) total += longint'(buf_d[i]);
            end
            run_packet("rand", buf_d, n, 1'b1, $urandom_range(0, 3),
                       model_sum(total), (total > 65535), 8'(n));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
